// File: rtl/sc_pkg.sv
// Shared types and defaults for the stochastic-to-binary capture block.
package sc_pkg;

    localparam int DEFAULT_LOG_LEN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/sc_ones_counter.sv
// Bit-index and ones-count for one conversion window of 2^LOG_LEN bits.
// term_o flags the accepted bit that completes the window.
module sc_ones_counter
    import sc_pkg::*;
#(
    parameter int LOG_LEN = DEFAULT_LOG_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               inc_i,
    input  logic               bit_i,
    output logic [LOG_LEN:0]   count_o,
    output logic               term_o
);

    localparam int CW = LOG_LEN + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'((1 << LOG_LEN) - 1);

    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] index_q, index_d;

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        count_d = count_q;
        index_d = index_q;
        if (clear_i) begin
            count_d = '0;
            index_d = '0;
        end else if (inc_i) begin
            index_d = index_q + 1'b1;
            count_d = count_q + CW'(bit_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            index_q <= '0;
        end else begin
            count_q <= count_d;
            index_q <= index_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = inc_i && !clear_i && (index_q == LAST_IDX);

endmodule

// File: rtl/sc_s2b_capture.sv
// Stochastic bitstream to binary capture: counts ones over 2^LOG_LEN accepted bits.
// Define SC_S2B_BIPOLAR_EN to report the signed value 2*ones - 2^LOG_LEN instead.
module sc_s2b_capture
    import sc_pkg::*;
#(
    parameter int LOG_LEN = DEFAULT_LOG_LEN,
`ifdef SC_S2B_BIPOLAR_EN
    parameter int OUT_W   = LOG_LEN + 2
`else
    parameter int OUT_W   = LOG_LEN + 1
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bs_in,
    input  logic             bs_valid,
    output logic             bs_ready,
    output logic [OUT_W-1:0] result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    localparam int CW = LOG_LEN + 1;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] result_q, result_d;
    logic             cnt_clear;
    logic             cnt_inc;
    logic [CW-1:0]    cnt_ones;
    logic             cnt_term;
    logic [CW-1:0]    ones_final;

    sc_ones_counter #(
        .LOG_LEN (LOG_LEN)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cnt_clear),
        .inc_i   (cnt_inc),
        .bit_i   (bs_in),
        .count_o (cnt_ones),
        .term_o  (cnt_term)
    );

    // The completing bit is still in flight, so fold it into the captured count here.
    assign ones_final = cnt_ones + CW'(bs_in);

    function automatic logic [OUT_W-1:0] to_result(input logic [CW-1:0] ones);
`ifdef SC_S2B_BIPOLAR_EN
        return (OUT_W'(ones) << 1) - (OUT_W'(1) << LOG_LEN);
`else
        return OUT_W'(ones);
`endif
    endfunction

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_clear = 1'b1;
                    state_d   = COUNT;
                end
            end
            COUNT: begin
                if (bs_valid) begin
                    cnt_inc = 1'b1;
                    if (cnt_term) begin
                        state_d  = HOLD;
                        result_d = to_result(ones_final);
                    end
                end
            end
            HOLD: begin
                // A start alongside the release opens the next window with no bubble.
                if (res_ready) begin
                    if (start) begin
                        cnt_clear = 1'b1;
                        state_d   = COUNT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign bs_ready  = (state_q == COUNT);
    assign busy      = (state_q == COUNT);
    assign res_valid = (state_q == HOLD);
    assign result    = result_q;

endmodule

// File: tb/tb_sc_s2b_capture.sv
// Directed bench for sc_s2b_capture at LOG_LEN=4; honours SC_S2B_BIPOLAR_EN.
module tb_sc_s2b_capture;

    localparam int LOG_LEN = 4;
    localparam int NBITS   = 16;
`ifdef SC_S2B_BIPOLAR_EN
    localparam int OUT_W   = LOG_LEN + 2;
`else
    localparam int OUT_W   = LOG_LEN + 1;
`endif

    typedef struct {
        string       name;
        logic [15:0] bits;   // applied LSB first
        int          gap;    // bs_valid low every gap-th cycle, 0 = never
        int          hold;   // cycles res_ready stays low in HOLD
        int          ones;   // hand-counted ones in bits
    } vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             bs_in = 1'b0;
    logic             bs_valid = 1'b0;
    logic             bs_ready;
    logic [OUT_W-1:0] result;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic             busy;

    int n_vec  = 0;
    int n_miss = 0;

    sc_s2b_capture #(
        .LOG_LEN (LOG_LEN),
        .OUT_W   (OUT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bs_in     (bs_in),
        .bs_valid  (bs_valid),
        .bs_ready  (bs_ready),
        .result    (result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, wanted finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] exp_res(input int ones);
`ifdef SC_S2B_BIPOLAR_EN
        return OUT_W'(2 * ones - NBITS);
`else
        return OUT_W'(ones);
`endif
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feeds one window (optionally pulsing start first), then holds and releases the result.
    // With b2b set, start rides along with res_ready so the next window opens immediately.
    task automatic run_window(input vec_t v, input bit do_start, input bit b2b);
        int acc = 0;
        int cyc = 0;
        logic [15:0] pat;
        logic [OUT_W-1:0] exp;
        pat = v.bits;
        exp = exp_res(v.ones);
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        check({v.name, " busy in COUNT"}, busy, 1);
        check({v.name, " bs_ready in COUNT"}, bs_ready, 1);
        while (acc < NBITS && cyc < 200) begin
            cyc++;
            bs_valid = !(v.gap != 0 && (cyc % v.gap) == 0);
            bs_in    = pat[acc];
            if (bs_valid) acc++;
            step();
            bs_valid = 1'b0;
            bs_in    = 1'b0;
            if (acc == NBITS - 1 && bs_valid == 1'b0 && cyc < 200)
                ;
            if (acc < NBITS && acc == NBITS - 1)
                check({v.name, " res_valid before last bit"}, res_valid, 0);
        end
        if (acc < NBITS) begin
            check({v.name, " window timeout accepted bits"}, acc, NBITS);
            return;
        end
        check({v.name, " res_valid after last bit"}, res_valid, 1);
        check({v.name, " result"}, result, exp);
        for (int i = 0; i < v.hold; i++) begin
            step();
            if (res_valid !== 1'b1 || result !== exp || bs_ready !== 1'b0) begin
                check({v.name, " hold res_valid"}, res_valid, 1);
                check({v.name, " hold result"}, result, exp);
                check({v.name, " hold bs_ready"}, bs_ready, 0);
            end
        end
        if (v.hold > 0) begin
            check({v.name, " held result"}, result, exp);
            check({v.name, " held bs_ready"}, bs_ready, 0);
        end
        res_ready = 1'b1;
        start     = b2b;
        step();
        res_ready = 1'b0;
        start     = 1'b0;
        check({v.name, " res_valid released"}, res_valid, 0);
        check({v.name, " result kept after release"}, result, exp);
        check({v.name, " busy after release"}, busy, b2b ? 1 : 0);
    endtask

    vec_t vecs[5];

    initial begin
        vec_t ones_v;
        vecs[0] = '{name: "all_ones",  bits: 16'hFFFF, gap: 0, hold: 0, ones: 16};
        vecs[1] = '{name: "alt_gap3",  bits: 16'h5555, gap: 3, hold: 0, ones: 8};
        vecs[2] = '{name: "zeros_hold", bits: 16'h0000, gap: 0, hold: 5, ones: 0};
        vecs[3] = '{name: "mix_00f3",  bits: 16'h00F3, gap: 0, hold: 1, ones: 6};
        vecs[4] = '{name: "ends_gap2", bits: 16'h8001, gap: 2, hold: 2, ones: 2};

        // Reset state
        #2;
        check("reset result", result, 0);
        check("reset res_valid", res_valid, 0);
        check("reset bs_ready", bs_ready, 0);
        check("reset busy", busy, 0);
        step();
        rst = 1'b1;
        step();

        // Start ignored while idle is fine; bits offered in IDLE must not count.
        bs_valid = 1'b1;
        bs_in    = 1'b1;
        step();
        bs_valid = 1'b0;
        bs_in    = 1'b0;
        check("idle bs_ready", bs_ready, 0);
        check("idle busy", busy, 0);

        for (int i = 0; i < 5; i++) run_window(vecs[i], 1'b1, 1'b0);

        // Back-to-back windows: release and start in the same HOLD cycle.
        run_window(vecs[3], 1'b1, 1'b1);
        check("b2b res_valid in new COUNT", res_valid, 0);
        run_window(vecs[1], 1'b0, 1'b0);

        // Start in COUNT and in HOLD without res_ready must be ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            bs_valid = 1'b1;
            bs_in    = (i < 3);
            start    = (i == 5);
            step();
        end
        bs_valid = 1'b0;
        bs_in    = 1'b0;
        check("ignored start res_valid", res_valid, 1);
        check("ignored start result", result, exp_res(3));
        start = 1'b1;
        step();
        start = 1'b0;
        check("start without res_ready stays HOLD", res_valid, 1);
        check("start without res_ready not busy", busy, 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("release to idle busy", busy, 0);

        // Asynchronous reset after 7 ones of a window discards the partial count.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bs_valid = 1'b1;
            bs_in    = 1'b1;
            step();
        end
        bs_valid = 1'b0;
        bs_in    = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mid reset result", result, 0);
        check("mid reset res_valid", res_valid, 0);
        check("mid reset bs_ready", bs_ready, 0);
        check("mid reset busy", busy, 0);
        step();
        rst = 1'b1;
        step();
        step();
        check("post reset no res_valid", res_valid, 0);
        ones_v = '{name: "after_reset", bits: 16'hFFFF, gap: 0, hold: 0, ones: 16};
        run_window(ones_v, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sc_s2b_capture.md
SC_S2B_CAPTURE -- requirements
Module: sc_s2b_capture

Interface
REQ-001 SHALL have parameter LOG_LEN, default 8: stream length is 2^LOG_LEN bits.
REQ-002 SHALL have parameter OUT_W, default LOG_LEN+1: result width, wide enough to hold the value 2^LOG_LEN.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: pulse that opens a new conversion window.
REQ-006 SHALL have port bs_in, input, 1 bit: stochastic bitstream, e.g. the AND of two SNG outputs.
REQ-007 SHALL have port bs_valid, input, 1 bit: bs_in is meaningful this cycle.
REQ-008 SHALL have port bs_ready, output, 1 bit: block accepts a bit this cycle.
REQ-009 SHALL have port result, output, OUT_W bits: captured ones-count (or bipolar value, REQ-024).
REQ-010 SHALL have port res_valid, output, 1 bit: result holds a completed window.
REQ-011 SHALL have port res_ready, input, 1 bit: consumer accepts result.
REQ-012 SHALL have port busy, output, 1 bit: a window is in progress.

Function
REQ-013 SHALL implement FSM states IDLE, COUNT and HOLD.
REQ-014 IDLE: bs_ready=0, busy=0; start=1 moves to COUNT next cycle, with the ones-count and bit-index cleared to 0.
REQ-015 COUNT: bs_ready=1, busy=1; each cycle with bs_valid=1 increments the bit-index, and also increments the ones-count if bs_in=1.
REQ-016 A cycle in COUNT with bs_valid=0 SHALL change no state.
REQ-017 On the accepted bit that brings the bit-index to 2^LOG_LEN, the block SHALL:
- move to HOLD;
- load result with the final count, including that bit;
- assert res_valid on the next cycle.
REQ-018 HOLD: bs_ready=0, res_valid=1, result stable; res_valid&&res_ready returns to IDLE the next cycle.
REQ-019 In HOLD, start=1 together with res_ready=1 SHALL go directly to COUNT with counters cleared (back-to-back windows, zero bubble).
REQ-020 start SHALL be ignored in COUNT, and in HOLD when res_ready=0.
REQ-021 The ones-count SHALL never wrap: the maximum is 2^LOG_LEN (all ones), representable in OUT_W bits.
REQ-022 result SHALL update only on window completion; it holds its value between windows.

Reset
REQ-023 On rst=0, asynchronously:
- state=IDLE;
- counters=0, result=0;
- res_valid=0, bs_ready=0, busy=0.
Reset mid-COUNT or mid-HOLD discards the partial or pending result; no res_valid follows.

Configuration
REQ-024 With SC_S2B_BIPOLAR_EN defined, result SHALL be the signed two's-complement value 2*ones - 2^LOG_LEN (range -2^LOG_LEN to +2^LOG_LEN), so OUT_W SHALL be LOG_LEN+2.
REQ-025 Without SC_S2B_BIPOLAR_EN, result SHALL be the unsigned ones-count, and no bipolar logic is synthesized.

Structure
REQ-026 The shared package sc_pkg SHALL hold:
- the FSM state enum typedef (IDLE/COUNT/HOLD);
- the default LOG_LEN constant.
REQ-027 The ones/index counting SHALL live in one sub-module, sc_ones_counter:
- inputs: clear, inc, bit;
- outputs: count and index-terminal flag.
The FSM and handshake stay in the top.

Verification
REQ-028 LOG_LEN=4, start, 16 valid bits all 1 -> result=16, res_valid 1 cycle after the 16th bit; bipolar build -> +16.
REQ-029 LOG_LEN=4, alternating 1/0 bits with bs_valid low every third cycle -> result=8 after exactly 16 accepted bits; bipolar -> 0.
REQ-030 All-zero stream, res_ready held 0 for 5 cycles -> res_valid and result=0 remain stable, bs_ready=0 throughout; bipolar -> -16.
REQ-031 In HOLD, start and res_ready both 1 in the same cycle -> COUNT next cycle, counters 0, second window completes independently with correct count.
REQ-032 rst asserted after 7 bits of a window -> all outputs 0 immediately; subsequent start plus 16 ones -> result=16, not 23.
